program_loader_rom: RTL
=======================

// Module: program_loader_rom
// PURPOSE
//  Instruction store directly upstream of the Microprocessor core: maps core pc -> 8-bit instruction
//  {op[1:0], rs[1:0], rt[1:0], rd/imm[1:0]}. Loadable at runtime over a valid/ready byte stream.
//  Holds the core (cpu_hold) while clearing or loading, so the core only ever fetches a complete program.
// PARAMETERS
//  ADDR_W   8      pc / store address width; DEPTH = 2**ADDR_W words
//  INSN_W   8      instruction width
//  NOP_INSN 8'h00  fill value for unloaded words
// PORTS
//  origclk      in   1         sole clock, rising edge
//  reset_n      in   1         asynchronous, active-low reset
//  load_start   in   1         request a new program load; accepted only in RUN
//  load_valid   in   1         load_data is valid this cycle
//  load_data    in   INSN_W    program word; written at the next sequential address
//  load_last    in   1         qualifies the final word of the program (sampled with valid&ready)
//  load_ready   out  1         store accepts a word this cycle
//  load_done    out  1         one-cycle pulse on return to RUN after a load
//  load_count   out  ADDR_W+1  words accepted by the most recent load
//  cpu_hold     out  1         high: core must stay in reset / not advance
//  pc           in   ADDR_W    fetch address from core
//  instruction  out  INSN_W    fetched instruction to core
// BEHAVIOUR
//  States: FILL, RUN, LOAD. Registers: state, wr_ptr[ADDR_W-1:0], load_count, load_done.
//  Reset (async assert): state=FILL, wr_ptr=0, load_count=0, load_done=0; cpu_hold=1, load_ready=0.
//   Array contents are not reset; FILL makes them deterministic.
//  FILL: each cycle writes NOP_INSN at wr_ptr, wr_ptr++. After writing DEPTH-1 -> RUN.
//   load_start ignored. cpu_hold=1, load_ready=0.
//  RUN: cpu_hold=0, load_ready=0. load_start=1 -> LOAD next cycle, wr_ptr=0, load_count=0.
//  LOAD: load_ready=1, cpu_hold=1. A beat is load_valid&load_ready: write load_data at wr_ptr, load_count++.
//   - Beat with load_last and wr_ptr<DEPTH-1 -> FILL with wr_ptr=wr_ptr+1 (clears stale tail).
//   - Beat at wr_ptr==DEPTH-1 (store full) -> RUN directly; load_last irrelevant. load_count=DEPTH.
//   - Else wr_ptr++. No beat: hold. load_start ignored.
//  load_done: registered, 1 for exactly the first RUN cycle after a LOAD (through FILL or direct).
//   Not asserted after the reset-time FILL.
//  Write path is synchronous (one write/cycle); instruction = (state==RUN) ? mem[pc] : NOP_INSN,
//   combinational read, zero latency; a write and a read of the same address never coincide (hold).
//  wr_ptr arithmetic modulo DEPTH; never wraps in practice (terminal checks above).
//  Reset mid-LOAD or mid-FILL: abort immediately; restart FILL from 0; partial program discarded.
//  load_count holds its value through RUN until the next accepted load_start.
// STRUCTURE
//  Shared package isa_pkg: INSN_W, NOP_INSN, opcode constants (OP_ADD=0, OP_LW=1, OP_SW=2, OP_BEQ=3),
//   field slices for op/rs/rt/rd.
//  Sub-module prog_mem_array: DEPTH x INSN_W, one sync write port, one async read port, no reset.
//  Top holds FSM, wr_ptr, counters and output muxing.
// TESTING
//  1 Reset: release reset_n -> cpu_hold=1 for DEPTH cycles, then RUN; all pc in 0..255 read 8'h00; no load_done.
//  2 Load 5 words 8'h64,8'h69,8'h18,8'h89,8'hC3 (last on 5th) -> load_count=5, FILL 251 cycles,
//    load_done pulse 1 cycle; pc=3 reads 8'h89, pc=5 reads 8'h00.
//  3 Backpressure/gaps: load_valid toggled 1-0-0-1 with 2 words -> exactly 2 writes, no duplicates, count=2.
//  4 Full store: 256 beats without load_last -> RUN right after beat 256, load_count=256, pc=255 = last word.
//  5 Reset_n asserted after 3 beats of a load -> FILL from 0, cpu_hold=1, pc=0 reads 8'h00 after fill; no load_done.
//  6 load_start during FILL and during LOAD -> ignored; state sequence and load_count unchanged.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction store and the core it feeds.
// The 8-bit instruction packs {op, rs, rt, rd/imm}, with two bits per field.
package isa_pkg;
    localparam int              INSN_W   = 8;
    localparam logic [INSN_W-1:0] NOP_INSN = 8'h00;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_LW  = 2'd1;
    localparam logic [1:0] OP_SW  = 2'd2;
    localparam logic [1:0] OP_BEQ = 2'd3;

    typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_LOAD} ld_state_e;

    function automatic logic [1:0] insn_op(input logic [INSN_W-1:0] insn);
        return insn[7:6];
    endfunction
    function automatic logic [1:0] insn_rs(input logic [INSN_W-1:0] insn);
        return insn[5:4];
    endfunction
    function automatic logic [1:0] insn_rt(input logic [INSN_W-1:0] insn);
        return insn[3:2];
    endfunction
    function automatic logic [1:0] insn_rd(input logic [INSN_W-1:0] insn);
        return insn[1:0];
    endfunction
endpackage

// File: rtl/prog_mem_array.sv
// Program store: one synchronous write port and one combinational read port.
// The array has no reset; the loader clears it by sweeping NOPs through it.
module prog_mem_array #(
    parameter int ADDR_W = 8,
    parameter int INSN_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [INSN_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [INSN_W-1:0] o_rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [INSN_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/program_loader_rom.sv
// Runtime-loadable instruction store feeding the core. The core is held off
// while the store is being cleared or loaded, so it only ever fetches a whole program.
module program_loader_rom #(
    parameter int                ADDR_W   = 8,
    parameter int                INSN_W   = isa_pkg::INSN_W,
    parameter logic [INSN_W-1:0] NOP_INSN = isa_pkg::NOP_INSN
) (
    input  logic              origclk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [INSN_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              cpu_hold,
    input  logic [ADDR_W-1:0] pc,
    output logic [INSN_W-1:0] instruction
);
    import isa_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    ld_state_e         r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [ADDR_W:0]   r_load_count, w_load_count_nxt;
    logic              r_load_done, w_load_done_nxt;
    logic              r_after_load, w_after_load_nxt;
    logic              w_we;
    logic [INSN_W-1:0] w_wdata;
    logic [INSN_W-1:0] w_rdata;
    logic              w_beat;

    assign w_beat = load_valid & load_ready;

    always_ff @(posedge origclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_FILL;
            r_wr_ptr     <= '0;
            r_load_count <= '0;
            r_load_done  <= 1'b0;
            r_after_load <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_load_count <= w_load_count_nxt;
            r_load_done  <= w_load_done_nxt;
            r_after_load <= w_after_load_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_load_count_nxt = r_load_count;
        w_after_load_nxt = r_after_load;
        w_we             = 1'b0;
        w_wdata          = NOP_INSN;
        cpu_hold         = 1'b1;
        load_ready       = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_we         = 1'b1;
                w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                if (r_wr_ptr == LAST_ADDR) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                cpu_hold         = 1'b0;
                w_after_load_nxt = 1'b0;
                if (load_start) begin
                    w_state_nxt      = ST_LOAD;
                    w_wr_ptr_nxt     = '0;
                    w_load_count_nxt = '0;
                end
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                if (w_beat) begin
                    w_we             = 1'b1;
                    w_wdata          = load_data;
                    w_load_count_nxt = r_load_count + 1'b1;
                    w_wr_ptr_nxt     = r_wr_ptr + 1'b1;
                    // A full store ends the load regardless of load_last.
                    if (r_wr_ptr == LAST_ADDR) begin
                        w_state_nxt = ST_RUN;
                    end else if (load_last) begin
                        w_state_nxt      = ST_FILL;
                        w_after_load_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // Pulse only on entry to RUN following a load, never after the reset-time clear.
    assign w_load_done_nxt = (w_state_nxt == ST_RUN) &&
                             ((r_state == ST_LOAD) || (r_state == ST_FILL && r_after_load));

    prog_mem_array #(
        .ADDR_W (ADDR_W),
        .INSN_W (INSN_W)
    ) u_mem (
        .i_clk   (origclk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (pc),
        .o_rdata (w_rdata)
    );

    assign instruction = (r_state == ST_RUN) ? w_rdata : NOP_INSN;
    assign load_done   = r_load_done;
    assign load_count  = r_load_count;
endmodule
